// File: rtl/mem_copy_engine.sv
// Byte-wise block copy initiator for the single-port synchronous memory (read, then write, per byte).
// Optional build macro COPY_CHECKSUM_EN adds an XOR checksum output over all bytes written.
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] read_data
`ifdef COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          count_d = '0;
          state_d = (length != '0) ? READ : DONE;
        end
      end
      READ: state_d = XFER;
      XFER: begin
        count_d = count_q + 1'b1;
        state_d = (count_d == len_q) ? DONE : READ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are pure Moore outputs
  // and the async reset clears them immediately.
  always_comb begin
    busy_d  = (state_d == READ) || (state_d == XFER);
    done_d  = (state_d == DONE);
    read_d  = (state_d == READ);
    write_d = (state_d == XFER);
    addr_d  = '0;
    case (state_d)
      READ:    addr_d = src_d + count_d[ADDR_W-1:0];
      XFER:    addr_d = dst_d + count_d[ADDR_W-1:0];
      default: addr_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_read   = read_q;
  assign mem_write  = write_q;
  assign address    = addr_q;
  // Read data from the previous READ cycle is forwarded straight to the memory write port.
  assign write_data = write_q ? read_data : '0;

`ifdef COPY_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (state_q == IDLE && start) begin
      chk_d = '0;
    end else if (state_q == XFER) begin
      chk_d = chk_q ^ read_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed scenarios plus random copies against an array-based reference.
// Build with COPY_CHECKSUM_EN defined to also check the checksum output.
module tb_mem_copy_engine;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [8:0] length;
  logic       busy;
  logic       done;
  logic [7:0] address;
  logic [7:0] write_data;
  logic       mem_write;
  logic       mem_read;
  logic [7:0] read_data;
`ifdef COPY_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem    [256];
  logic [7:0] refMem [256];
  logic       fillReq;

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .address    (address),
    .write_data (write_data),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .read_data  (read_data)
`ifdef COPY_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory with one-cycle registered read; fillReq copies the reference image in.
  always @(posedge clk) begin
    if (fillReq) begin
      for (int i = 0; i < 256; i++) mem[i] <= refMem[i];
    end else begin
      if (mem_write) mem[address] <= write_data;
      if (mem_read) read_data <= mem[address];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference copy: ascending byte moves on the model array; returns XOR of the bytes written.
  function automatic logic [7:0] refCopy(input logic [7:0] s, input logic [7:0] d, input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      refMem[8'(d + i)] = refMem[8'(s + i)];
      x ^= refMem[8'(d + i)];
    end
    return x;
  endfunction

  task automatic syncMemory();
    @(negedge clk);
    fillReq = 1'b1;
    @(posedge clk);
    #1 fillReq = 1'b0;
  endtask

  task automatic checkMemory(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) diffs++;
    checkOutput(tag, diffs, 0);
  endtask

  // One complete copy: start on a single edge, scramble inputs afterwards, trace the bus until done.
  task automatic applyStimulus(input string tag, input logic [7:0] s, input logic [7:0] d, input int n);
    int doneCycle, nBusy, nRead, nWrite, addrErr, overlap;
    logic [7:0] expChk;
    logic [7:0] gotChk;
    doneCycle = -1; nBusy = 0; nRead = 0; nWrite = 0; addrErr = 0; overlap = 0;
    gotChk = 8'h00;
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = 9'(n);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    src_addr = 8'($urandom);
    dst_addr = 8'($urandom);
    length   = 9'($urandom);
    for (int k = 1; k <= 2 * n + 10; k++) begin
      @(negedge clk);
      if (mem_read) begin
        if (address !== 8'(s + nRead)) addrErr++;
        nRead++;
      end
      if (mem_write) begin
        if (address !== 8'(d + nWrite)) addrErr++;
        nWrite++;
      end
      if (mem_read && mem_write) overlap++;
      if (busy) nBusy++;
      if (done) begin
        doneCycle = k;
`ifdef COPY_CHECKSUM_EN
        gotChk = checksum;
`endif
        break;
      end
    end
    expChk = refCopy(s, d, n);
    checkOutput({tag, " doneCycle"}, doneCycle, 2 * n + 1);
    checkOutput({tag, " busyCycles"}, nBusy, 2 * n);
    checkOutput({tag, " reads"}, nRead, n);
    checkOutput({tag, " writes"}, nWrite, n);
    checkOutput({tag, " addrErrors"}, addrErr, 0);
    checkOutput({tag, " rdWrOverlap"}, overlap, 0);
`ifdef COPY_CHECKSUM_EN
    checkOutput({tag, " checksum"}, gotChk, expChk);
`else
    if (gotChk !== 8'h00) $display("[TB] note: unexpected checksum capture %s", tag);
`endif
    @(negedge clk);
    checkOutput({tag, " donePulseEnd"}, {busy, done}, 2'b00);
    checkMemory({tag, " memory"});
  endtask

  initial begin
    int dones, firstDone, secondDone;
    logic busy8, busy9;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0; fillReq = 1'b0;
    for (int i = 0; i < 256; i++) refMem[i] = 8'($urandom);
    #12;
    checkOutput("reset outputs", {busy, done, mem_read, mem_write, address, write_data}, 20'h0);
    syncMemory();
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    // Basic copy with known data
    refMem[8'h10] = 8'hA1; refMem[8'h11] = 8'hB2; refMem[8'h12] = 8'hC3; refMem[8'h13] = 8'hD4;
    syncMemory();
    applyStimulus("basic", 8'h10, 8'h80, 4);
    checkOutput("basic dst byte3", mem[8'h83], 8'hD4);

    applyStimulus("len0", 8'h33, 8'h44, 0);

    refMem[8'hFE] = 8'h11; refMem[8'hFF] = 8'h22; refMem[8'h00] = 8'h33; refMem[8'h01] = 8'h44;
    syncMemory();
    applyStimulus("wrap", 8'hFE, 8'h40, 4);
    checkOutput("wrap dst byte2", mem[8'h42], 8'h33);

    refMem[8'h20] = 8'h5A;
    syncMemory();
    applyStimulus("overlap", 8'h20, 8'h21, 3);
    checkOutput("overlap dst byte3", mem[8'h23], 8'h5A);

    // start held high for many cycles: second copy only after returning to IDLE
    @(negedge clk);
    src_addr = 8'h50; dst_addr = 8'h60; length = 9'd3; start = 1'b1;
    dones = 0; firstDone = -1; secondDone = -1; busy8 = 1'b0; busy9 = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (firstDone < 0) firstDone = k; else secondDone = k;
      end
      if (k == 8) busy8 = busy;
      if (k == 9) begin
        busy9 = busy;
        start = 1'b0;
      end
    end
    void'(refCopy(8'h50, 8'h60, 3));
    void'(refCopy(8'h50, 8'h60, 3));
    checkOutput("hold doneCount", dones, 2);
    checkOutput("hold firstDone", firstDone, 7);
    checkOutput("hold secondDone", secondDone, 15);
    checkOutput("hold idleGap", {busy8, busy9}, 2'b01);
    checkMemory("hold memory");

    // Reset during the write of byte 2 of a 5-byte copy
    for (int i = 0; i < 5; i++) refMem[8'hA0 + i] = 8'hE0 + 8'(i);
    syncMemory();
    @(negedge clk);
    src_addr = 8'h90; dst_addr = 8'hA0; length = 9'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    checkOutput("abort preWrite", {mem_write, address}, {1'b1, 8'hA2});
    rst = 1'b1;
    #1;
    checkOutput("abort strobes", {busy, done, mem_read, mem_write, address}, 12'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checkOutput("abort quiet", dones, 0);
    void'(refCopy(8'h90, 8'hA0, 2));
    checkMemory("abort memory");

    for (int t = 0; t < 8; t++) begin
      applyStimulus($sformatf("rand%0d", t), 8'($urandom), 8'($urandom), int'($urandom_range(0, 24)));
    end

    applyStimulus("full", 8'h00, 8'h80, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
